// File: rtl/alarm_trigger_pkg.sv
// Shared clock-UI definitions: mode codes, button one-hot codes and RTC time packing.
package alarm_trigger_pkg;

    localparam logic [3:0] MODE_ALARM_SET = 4'b0111;

    // BUTTONS bus order is {UP, DOWN, CENTER, LEFT, RIGHT}.
    localparam logic [4:0] BTN_UP     = 5'b10000;
    localparam logic [4:0] BTN_DOWN   = 5'b01000;
    localparam logic [4:0] BTN_CENTER = 5'b00100;
    localparam logic [4:0] BTN_LEFT   = 5'b00010;
    localparam logic [4:0] BTN_RIGHT  = 5'b00001;

    // RTC word is {x, hour[16:12], min[11:6], sec[5:0]}; bit 17 carries no time.
    localparam logic [17:0] RTC_TIME_MASK = 18'h1_FFFF;

    typedef enum logic [1:0] {
        AT_IDLE    = 2'd0,
        AT_RINGING = 2'd1,
        AT_SNOOZE  = 2'd2
    } alarm_state_e;

    function automatic logic is_button_code(input logic [4:0] p);
        return (p == BTN_UP) || (p == BTN_DOWN) || (p == BTN_CENTER) ||
               (p == BTN_LEFT) || (p == BTN_RIGHT);
    endfunction

    function automatic logic rtc_same_time(input logic [17:0] a, input logic [17:0] b);
        return ((a ^ b) & RTC_TIME_MASK) == 18'd0;
    endfunction

endpackage

// File: rtl/alarm_trigger_button_edge.sv
// Rising-edge detector for the debounced button bus; passes a press only when it is
// a single recognised button code, otherwise reports no press.
module alarm_trigger_button_edge
    import alarm_trigger_pkg::*;
(
    input  logic       CLK,
    input  logic       RESETN,
    input  logic [4:0] i_buttons,
    output logic [4:0] o_press
);

    logic [4:0] r_prev;
    logic [4:0] w_rise;

    always_ff @(posedge CLK or negedge RESETN) begin
        if (!RESETN) begin
            r_prev <= 5'd0;
        end else begin
            r_prev <= i_buttons;
        end
    end

    assign w_rise  = (i_buttons ^ r_prev) & i_buttons;
    assign o_press = is_button_code(w_rise) ? w_rise : 5'd0;

endmodule

// File: rtl/alarm_trigger.sv
// Alarm trigger: matches live RTC time against the programmed alarm on each second
// change and runs the ringing / snooze / timeout sequence that drives the buzzer.
module alarm_trigger
    import alarm_trigger_pkg::*;
#(
    parameter logic [3:0]  ALARM_SET_STATE  = MODE_ALARM_SET,
    parameter logic [9:0]  RING_SECONDS     = 10'd60,
    parameter logic [9:0]  SNOOZE_SECONDS   = 10'd300,
    parameter logic [2:0]  MAX_SNOOZE       = 3'd3,
    parameter logic [31:0] BEEP_HALF_CYCLES = 32'd25_000_000
) (
    input  logic        CLK,
    input  logic        RESETN,
    input  logic [3:0]  STATE,
    input  logic [4:0]  BUTTONS,
    input  logic [17:0] RTC_DATA,
    input  logic [17:0] ALARM_SET_DATA,
    input  logic        ALARM_SET_FLAG,
    output logic        ALARM_RINGING,
    output logic        SNOOZE_ACTIVE,
    output logic        BUZZER,
    output logic [2:0]  SNOOZE_COUNT,
    output logic        ALARM_EVENT
);

    alarm_state_e r_state;
    alarm_state_e w_state_nxt;
    logic [9:0]   r_ring_cnt, w_ring_nxt, w_ring_dec;
    logic [9:0]   r_snz_cnt, w_snz_nxt, w_snz_dec;
    logic [2:0]   r_snz_used, w_snz_used_nxt;
    logic [31:0]  r_beep_cnt;
    logic         r_buzzer;
    logic         r_event;
    logic [17:0]  r_rtc_prev;
    logic         r_rtc_valid;
    logic [4:0]   w_press;
    logic         w_sec_tick, w_match, w_press_center, w_press_snooze;

    alarm_trigger_button_edge u_button_edge (
        .CLK       (CLK),
        .RESETN    (RESETN),
        .i_buttons (BUTTONS),
        .o_press   (w_press)
    );

    // rtc_valid masks the first post-reset cycle so reset-cleared history never looks like a tick.
    always_ff @(posedge CLK or negedge RESETN) begin
        if (!RESETN) begin
            r_rtc_prev  <= 18'd0;
            r_rtc_valid <= 1'b0;
        end else begin
            r_rtc_prev  <= RTC_DATA;
            r_rtc_valid <= 1'b1;
        end
    end

    assign w_sec_tick     = r_rtc_valid && (RTC_DATA != r_rtc_prev);
    assign w_match        = w_sec_tick && ALARM_SET_FLAG && (STATE != ALARM_SET_STATE) &&
                            rtc_same_time(RTC_DATA, ALARM_SET_DATA);
    assign w_press_center = (w_press == BTN_CENTER);
    assign w_press_snooze = (w_press == BTN_UP) || (w_press == BTN_DOWN);
    assign w_ring_dec     = (r_ring_cnt == 10'd0) ? 10'd0 : r_ring_cnt - 10'd1;
    assign w_snz_dec      = (r_snz_cnt == 10'd0) ? 10'd0 : r_snz_cnt - 10'd1;

    always_ff @(posedge CLK or negedge RESETN) begin
        if (!RESETN) begin
            r_state <= AT_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt    = r_state;
        w_ring_nxt     = r_ring_cnt;
        w_snz_nxt      = r_snz_cnt;
        w_snz_used_nxt = r_snz_used;
        case (r_state)
            AT_IDLE: begin
                if (w_match) begin
                    w_state_nxt    = AT_RINGING;
                    w_ring_nxt     = RING_SECONDS;
                    w_snz_used_nxt = 3'd0;
                end
            end
            AT_RINGING: begin
                if (!ALARM_SET_FLAG || w_press_center) begin
                    w_state_nxt = AT_IDLE;
                end else if (w_press_snooze) begin
                    // Once the snooze allowance is spent, a snooze press dismisses instead.
                    if (r_snz_used < MAX_SNOOZE) begin
                        w_state_nxt    = AT_SNOOZE;
                        w_snz_nxt      = SNOOZE_SECONDS;
                        w_snz_used_nxt = r_snz_used + 3'd1;
                    end else begin
                        w_state_nxt = AT_IDLE;
                    end
                end else if (w_sec_tick) begin
                    w_ring_nxt = w_ring_dec;
                    if (w_ring_dec == 10'd0) begin
                        w_state_nxt = AT_IDLE;
                    end
                end
            end
            AT_SNOOZE: begin
                if (!ALARM_SET_FLAG || w_press_center) begin
                    w_state_nxt = AT_IDLE;
                end else if (w_sec_tick) begin
                    w_snz_nxt = w_snz_dec;
                    if (w_snz_dec == 10'd0) begin
                        w_state_nxt = AT_RINGING;
                        w_ring_nxt  = RING_SECONDS;
                    end
                end
            end
            default: w_state_nxt = AT_IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge RESETN) begin
        if (!RESETN) begin
            r_ring_cnt <= 10'd0;
            r_snz_cnt  <= 10'd0;
            r_snz_used <= 3'd0;
            r_event    <= 1'b0;
            r_buzzer   <= 1'b0;
            r_beep_cnt <= 32'd0;
        end else begin
            r_ring_cnt <= w_ring_nxt;
            r_snz_cnt  <= w_snz_nxt;
            r_snz_used <= w_snz_used_nxt;
            r_event    <= (r_state == AT_IDLE) && (w_state_nxt == AT_RINGING);
            // Every entry into RINGING restarts the beep pattern on its high phase.
            if (w_state_nxt != AT_RINGING) begin
                r_buzzer   <= 1'b0;
                r_beep_cnt <= 32'd0;
            end else if (r_state != AT_RINGING) begin
                r_buzzer   <= 1'b1;
                r_beep_cnt <= 32'd0;
            end else if (r_beep_cnt >= BEEP_HALF_CYCLES - 32'd1) begin
                r_buzzer   <= ~r_buzzer;
                r_beep_cnt <= 32'd0;
            end else begin
                r_beep_cnt <= r_beep_cnt + 32'd1;
            end
        end
    end

    always_comb begin
        ALARM_RINGING = (r_state == AT_RINGING);
        SNOOZE_ACTIVE = (r_state == AT_SNOOZE);
        BUZZER        = r_buzzer;
        SNOOZE_COUNT  = r_snz_used;
        ALARM_EVENT   = r_event;
    end

endmodule
